// File: rtl/seg_pkg.sv
// Shared types and segment encodings for the matchstick display stage.
// Segments are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_e;

    function automatic logic [6:0] seg_digit(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
    function automatic logic [19:0] dabble_adjust(input logic [19:0] v);
        logic [19:0] r;
        r = v;
        for (int i = 0; i < 5; i++) begin
            if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_display_scan_if.sv
// Game-FSM to display-stage bundle: stick count and flags in, digit scan out.
interface seg_display_scan_if;

    logic [15:0] datain;
    logic        user;
    logic        wrong;
    logic        finish;
    logic [3:0]  grounds;
    logic [6:0]  display;

    modport master (
        output datain, user, wrong, finish,
        input  grounds, display
    );

    modport slave (
        input  datain, user, wrong, finish,
        output grounds, display
    );

endinterface

// File: rtl/bcd_double_dabble.sv
// Sequential binary-to-BCD converter: one load cycle, then sixteen add-3/shift cycles.
module bcd_double_dabble
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    conv_state_e state_q, state_d;
    logic [35:0] sr_q, sr_d;
    logic [3:0]  cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = {20'd0, bin};
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = {dabble_adjust(sr_q[35:16]), sr_q[15:0]} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign bcd  = sr_q[35:16];

endmodule

// File: rtl/seg_display_scan.sv
// Four-digit common-anode scan of the remaining stick count, with blanking and text messages.
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 16,
    parameter int unsigned BLINK_BITS   = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_display_scan_if.slave  bus
);

    logic [15:0]             last_q, last_d;
    logic                    conv_valid_q, conv_valid_d;
    logic [11:0]             bcd_q, bcd_d;
    logic                    ovf_q, ovf_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    digit_idx_t              idx_q, idx_d;
    logic [BLINK_BITS-1:0]   blink_q, blink_d;
    logic [3:0]              grounds_q, grounds_d;
    logic [6:0]              display_q, display_d;

    logic        start;
    logic        conv_busy;
    logic        conv_done;
    logic [19:0] conv_bcd;
    logic        unused_bcd_hi;
    logic        refresh_wrap;
    logic [6:0]  digit_seg;

    bcd_double_dabble u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bus.datain),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign unused_bcd_hi = ^conv_bcd[19:12];

    // A new conversion is launched whenever the converter is free and the shown value is stale.
    always_comb begin
        last_d       = last_q;
        conv_valid_d = conv_valid_q;
        bcd_d        = bcd_q;
        ovf_d        = ovf_q;
        start        = 1'b0;
        if (!conv_busy && (!conv_valid_q || (bus.datain != last_q))) begin
            start  = 1'b1;
            last_d = bus.datain;
        end
        if (conv_done) begin
            bcd_d        = conv_bcd[11:0];
            ovf_d        = (last_q > 16'd999);
            conv_valid_d = 1'b1;
        end
    end

    always_comb begin
        refresh_wrap = &refresh_q;
        refresh_d    = refresh_q + REFRESH_BITS'(1);
        blink_d      = blink_q + BLINK_BITS'(1);
        idx_d        = refresh_wrap ? idx_q + digit_idx_t'(1) : idx_q;
    end

    // Content of the digit about to be selected; finish outranks wrong outranks the count.
    always_comb begin
        digit_seg = SEG_BLANK;
        if (bus.finish) begin
            unique case (idx_d)
                2'd3: digit_seg = bus.user ? SEG_2 : SEG_1;
                2'd2: digit_seg = SEG_E;
                2'd1: digit_seg = SEG_N;
                default: digit_seg = SEG_D;
            endcase
        end else if (bus.wrong) begin
            if (!blink_q[BLINK_BITS-1]) begin
                unique case (idx_d)
                    2'd3: digit_seg = SEG_BLANK;
                    2'd2: digit_seg = SEG_E;
                    default: digit_seg = SEG_R;
                endcase
            end
        end else if (idx_d == 2'd3) begin
            digit_seg = bus.user ? SEG_2 : SEG_1;
        end else if (conv_valid_q) begin
            if (ovf_q) begin
                digit_seg = SEG_DASH;
            end else begin
                unique case (idx_d)
                    2'd2: digit_seg = (bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg_digit(bcd_q[11:8]);
                    2'd1: digit_seg = (bcd_q[11:4] == 8'd0) ? SEG_BLANK : seg_digit(bcd_q[7:4]);
                    default: digit_seg = seg_digit(bcd_q[3:0]);
                endcase
            end
        end
    end

    // grounds==1111 only right after reset, so d0 gets driven on the first clock.
    always_comb begin
        grounds_d = grounds_q;
        display_d = display_q;
        if (refresh_wrap || (grounds_q == 4'b1111)) begin
            grounds_d = ~(4'b0001 << idx_d);
            display_d = digit_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q       <= '0;
            conv_valid_q <= 1'b0;
            bcd_q        <= '0;
            ovf_q        <= 1'b0;
            refresh_q    <= '0;
            idx_q        <= '0;
            blink_q      <= '0;
            grounds_q    <= 4'b1111;
            display_q    <= SEG_BLANK;
        end else begin
            last_q       <= last_d;
            conv_valid_q <= conv_valid_d;
            bcd_q        <= bcd_d;
            ovf_q        <= ovf_d;
            refresh_q    <= refresh_d;
            idx_q        <= idx_d;
            blink_q      <= blink_d;
            grounds_q    <= grounds_d;
            display_q    <= display_d;
        end
    end

    assign bus.grounds = grounds_q;
    assign bus.display = display_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan with a 4-cycle digit slot and a 16-cycle blink period.
module tb_seg_display_scan;

    localparam int SLOT  = 4;
    localparam int BHALF = 8;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   ecount;

    seg_display_scan_if bus ();

    seg_display_scan #(
        .REFRESH_BITS (2),
        .BLINK_BITS   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges seen since reset was released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    function automatic logic [6:0] seg_num(input int v);
        logic [6:0] t [10];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[v];
    endfunction

    // Digit lit after e edges: a new slot is latched every SLOT edges, d0 first.
    function automatic int slot_digit(input int e);
        return ((e - e % SLOT) / SLOT) % 4;
    endfunction

    function automatic bit slot_hidden(input int e);
        int l;
        l = e - e % SLOT;
        return (l > 0) && (((l - 1) % (2 * BHALF)) >= BHALF);
    endfunction

    function automatic logic [6:0] exp_seg(input int d, input int num, input bit usr,
                                           input bit wr, input bit fin, input bit hidden,
                                           input bit valid);
        if (fin) begin
            if (d == 3) return seg_num(usr ? 2 : 1);
            if (d == 2) return 7'b0000110;
            if (d == 1) return 7'b0101011;
            return 7'b0100001;
        end
        if (wr) begin
            if (hidden || d == 3) return BLANK;
            return (d == 2) ? 7'b0000110 : 7'b0101111;
        end
        if (d == 3) return seg_num(usr ? 2 : 1);
        if (!valid) return BLANK;
        if (num > 999) return 7'b0111111;
        if (d == 2) return (num < 100) ? BLANK : seg_num(num / 100);
        if (d == 1) return (num < 10) ? BLANK : seg_num((num / 10) % 10);
        return seg_num(num % 10);
    endfunction

    function automatic logic [27:0] exp_scan(input int num, input bit usr);
        logic [27:0] r;
        for (int d = 0; d < 4; d++) r[d*7 +: 7] = exp_seg(d, num, usr, 1'b0, 1'b0, 1'b0, 1'b1);
        return r;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Records one full scan; bad counts wrong grounds patterns and mid-slot display changes.
    task automatic capture_scan(output logic [27:0] digs, output int bad);
        logic [6:0] prev;
        logic [3:0] gnd;
        int e;
        int d;
        digs = '1;
        bad  = 0;
        prev = BLANK;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            e   = ecount;
            d   = slot_digit(e);
            gnd = ~(4'b0001 << d);
            if (bus.grounds !== gnd) bad++;
            if (k > 0 && (e % SLOT) != 0 && bus.display !== prev) bad++;
            prev = bus.display;
            digs[d*7 +: 7] = bus.display;
        end
    endtask

    task automatic settle_and_scan(input int num, input bit usr, output logic [27:0] digs,
                                   output int bad);
        bus.datain = 16'(num);
        bus.user   = usr;
        wait_cycles(60);
        capture_scan(digs, bad);
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        bus.datain = 16'd100;
        bus.user   = 1'b0;
        bus.wrong  = 1'b0;
        bus.finish = 1'b0;
        wait_cycles(3);
        checks++;
        if (bus.grounds !== 4'b1111) begin
            failures++;
            $display("FAIL reset_grounds: got %b want 1111", bus.grounds);
        end
        checks++;
        if (bus.display !== BLANK) begin
            failures++;
            $display("FAIL reset_display: got %b want 1111111", bus.display);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.grounds !== 4'b1110 || bus.display !== BLANK) begin
            failures++;
            $display("FAIL first_cycle: got grounds=%b display=%b want 1110/1111111",
                     bus.grounds, bus.display);
        end
    endtask

    task automatic test_basic;
        logic [27:0] digs;
        int bad;
        settle_and_scan(100, 1'b0, digs, bad);
        checks++;
        if (digs !== exp_scan(100, 1'b0)) begin
            failures++;
            $display("FAIL basic_100: got %h want %h", digs, exp_scan(100, 1'b0));
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL basic_scan: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_small;
        logic [27:0] digs;
        int bad;
        settle_and_scan(7, 1'b1, digs, bad);
        checks++;
        if (digs !== exp_scan(7, 1'b1) || bad != 0) begin
            failures++;
            $display("FAIL small_7: got %h bad=%0d want %h bad=0", digs, bad, exp_scan(7, 1'b1));
        end
    endtask

    task automatic test_wrong_blink;
        logic [6:0] want;
        int e;
        bus.wrong = 1'b1;
        wait_cycles(8);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e    = ecount;
            want = exp_seg(slot_digit(e), 7, bus.user, 1'b1, 1'b0, slot_hidden(e), 1'b1);
            checks++;
            if (bus.display !== want) begin
                failures++;
                $display("FAIL wrong_blink e=%0d: got %b want %b", e, bus.display, want);
            end
        end
        bus.wrong = 1'b0;
    endtask

    task automatic test_finish;
        logic [6:0] want;
        int e;
        bus.user   = 1'b0;
        bus.wrong  = 1'b1;
        bus.finish = 1'b1;
        wait_cycles(8);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e    = ecount;
            want = exp_seg(slot_digit(e), 7, 1'b0, 1'b1, 1'b1, slot_hidden(e), 1'b1);
            checks++;
            if (bus.display !== want) begin
                failures++;
                $display("FAIL finish_1End e=%0d: got %b want %b", e, bus.display, want);
            end
        end
        bus.wrong  = 1'b0;
        bus.finish = 1'b0;
    endtask

    task automatic test_overflow;
        logic [27:0] digs;
        int bad;
        settle_and_scan(1000, 1'b0, digs, bad);
        checks++;
        if (digs !== exp_scan(1000, 1'b0) || bad != 0) begin
            failures++;
            $display("FAIL ovf_1000: got %h bad=%0d want %h", digs, bad, exp_scan(1000, 1'b0));
        end
        settle_and_scan(42, 1'b0, digs, bad);
        checks++;
        if (digs !== exp_scan(42, 1'b0) || bad != 0) begin
            failures++;
            $display("FAIL after_ovf_42: got %h bad=%0d want %h", digs, bad, exp_scan(42, 1'b0));
        end
    endtask

    task automatic test_random;
        logic [27:0] digs;
        int bad;
        int num;
        bit usr;
        for (int i = 0; i < 8; i++) begin
            case (i % 4)
                0:       num = int'($urandom_range(9, 0));
                1:       num = int'($urandom_range(99, 10));
                2:       num = int'($urandom_range(999, 100));
                default: num = int'($urandom_range(65535, 1000));
            endcase
            usr = 1'($urandom_range(1, 0));
            settle_and_scan(num, usr, digs, bad);
            checks++;
            if (digs !== exp_scan(num, usr) || bad != 0) begin
                failures++;
                $display("FAIL random num=%0d user=%0d: got %h bad=%0d want %h",
                         num, usr, digs, bad, exp_scan(num, usr));
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [27:0] digs;
        logic [6:0] want;
        int bad;
        int e;
        settle_and_scan(100, 1'b1, digs, bad);
        bus.datain = 16'd55;
        wait_cycles(5);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.grounds !== 4'b1111 || bus.display !== BLANK) begin
            failures++;
            $display("FAIL reset_mid_off: got %b/%b want 1111/1111111", bus.grounds, bus.display);
        end
        wait_cycles(2);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            e    = ecount;
            want = exp_seg(slot_digit(e), 55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.display !== want) begin
                failures++;
                $display("FAIL no_stale e=%0d: got %b want %b", e, bus.display, want);
            end
        end
        wait_cycles(45);
        capture_scan(digs, bad);
        checks++;
        if (digs !== exp_scan(55, 1'b1) || bad != 0) begin
            failures++;
            $display("FAIL reset_mid_55: got %h bad=%0d want %h", digs, bad, exp_scan(55, 1'b1));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_small();
        test_wrong_blink();
        test_finish();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
